// File: rtl/dti_pack.sv
// Shared constants, state encoding and CONDIS_ACK field layout for the DTI connection responder.
// Every value used by the responder and its outstanding-translation counter is defined here.
package dti_pack;
  localparam int TBU_NUM_WIDTH       = 6;
  localparam int TRANSACTION_MAX_NUM = 16;
  localparam int CUSTOM_DATA_WIDTH   = 80;
  localparam int CUSTOM_KEEP_WIDTH   = 10;
  localparam int OUT_CNT_WIDTH       = $clog2(TRANSACTION_MAX_NUM) + 1;

  localparam logic [3:0] DTI_MSG_CONDIS_ACK = 4'h3;

  localparam int CONDIS_MSG_LSB   = 0;
  localparam int CONDIS_STATE_BIT = 4;
  localparam int CONDIS_TOK_LSB   = 8;
  localparam int CONDIS_TID_LSB   = 16;
  localparam logic [CUSTOM_KEEP_WIDTH-1:0] CONDIS_KEEP = 10'h00f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_CON,
    ST_DENY,
    ST_CONNECTED,
    ST_DRAIN,
    ST_ACK_DIS
  } conn_state_e;

  function automatic logic [7:0] tok_clamp(input logic [7:0] req, input logic [7:0] max_tok);
    return (req > max_tok) ? max_tok : req;
  endfunction
endpackage

// File: rtl/dti_cr_tok_cnt.sv
// Saturating up/down counter of in-flight translations; registered count, combinational flags.
// Increments beyond i_limit and decrements below zero are refused and flagged instead.
module dti_cr_tok_cnt #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc_req,
  input  logic                 i_dec_req,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_ovf,
  output logic                 o_udf
);
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_inc;
  logic                 w_dec;

  assign o_ovf   = i_inc_req && (r_cnt >= i_limit);
  assign o_udf   = i_dec_req && (r_cnt == '0);
  assign w_inc   = i_inc_req && !o_ovf;
  assign w_dec   = i_dec_req && !o_udf;
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/dti_cr_conn_entry.sv
// Per-TBU connect/disconnect responder: one-beat CONDIS_ACK 1 cycle after con_req or drain end.
// Response beat holds stable under resp_ready=0; illegal requests are ignored and set sticky proto_err.
module dti_cr_conn_entry
  import dti_pack::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         accept_en,
  input  logic                         con_req,
  input  logic [TBU_NUM_WIDTH-1:0]     con_tid,
  input  logic [7:0]                   con_tok,
  input  logic                         dis_req,
  input  logic                         trans_req,
  input  logic                         trans_resp,
  input  logic                         resp_ready,
  output logic                         resp_valid,
  output logic [CUSTOM_DATA_WIDTH-1:0] resp_data,
  output logic [CUSTOM_KEEP_WIDTH-1:0] resp_keep,
  output logic                         resp_last,
  output logic                         connected,
  output logic                         idle,
  output logic [7:0]                   tok_granted,
  output logic [OUT_CNT_WIDTH-1:0]     outstanding,
  output logic                         proto_err
);
  conn_state_e                r_state;
  conn_state_e                w_state_nxt;
  logic [TBU_NUM_WIDTH-1:0]   r_tid;
  logic [7:0]                 r_tok;
  logic                       r_err;
  logic                       w_latch_tid;
  logic                       w_grant;
  logic                       w_tok_clr;
  logic                       w_ovf;
  logic                       w_udf;
  logic                       w_err;
  logic                       w_resp_vld;
  logic [OUT_CNT_WIDTH-1:0]   w_out;

  always_comb begin
    w_state_nxt = r_state;
    w_latch_tid = 1'b0;
    w_grant     = 1'b0;
    w_tok_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (con_req) begin
          w_latch_tid = 1'b1;
          if (accept_en && (con_tok != 8'd0)) begin
            w_grant     = 1'b1;
            w_state_nxt = ST_ACK_CON;
          end else begin
            w_state_nxt = ST_DENY;
          end
        end
      end
      ST_ACK_CON:   if (resp_ready) w_state_nxt = ST_CONNECTED;
      ST_DENY:      if (resp_ready) w_state_nxt = ST_IDLE;
      ST_CONNECTED: if (dis_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN:     if (w_out == '0) w_state_nxt = ST_ACK_DIS;
      ST_ACK_DIS: begin
        if (resp_ready) begin
          w_tok_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tid   <= '0;
      r_tok   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_tid) r_tid <= con_tid;
      if (w_grant) r_tok <= tok_clamp(con_tok, 8'(TRANSACTION_MAX_NUM));
      else if (w_tok_clr) r_tok <= '0;
      if (w_err) r_err <= 1'b1;
    end
  end

  // Only CONNECTED may open new translations; responses may still drain afterwards.
  dti_cr_tok_cnt #(
    .CNT_WIDTH (OUT_CNT_WIDTH)
  ) u_tok_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc_req (trans_req && (r_state == ST_CONNECTED)),
    .i_dec_req (trans_resp),
    .i_limit   (OUT_CNT_WIDTH'(r_tok)),
    .o_count   (w_out),
    .o_ovf     (w_ovf),
    .o_udf     (w_udf)
  );

  assign w_err = (trans_req && (r_state != ST_CONNECTED)) || w_ovf || w_udf ||
                 (dis_req && (r_state != ST_CONNECTED)) || (con_req && (r_state != ST_IDLE));

  assign w_resp_vld = (r_state == ST_ACK_CON) || (r_state == ST_DENY) || (r_state == ST_ACK_DIS);

  always_comb begin
    resp_data = '0;
    resp_keep = '0;
    resp_last = 1'b0;
    if (w_resp_vld) begin
      resp_data[CONDIS_MSG_LSB +: 4]   = DTI_MSG_CONDIS_ACK;
      resp_data[CONDIS_STATE_BIT]      = (r_state == ST_ACK_CON);
      if (r_state == ST_ACK_CON) resp_data[CONDIS_TOK_LSB +: 8] = r_tok;
      resp_data[CONDIS_TID_LSB +: TBU_NUM_WIDTH] = r_tid;
      resp_keep = CONDIS_KEEP;
      resp_last = 1'b1;
    end
  end

  assign resp_valid  = w_resp_vld;
  assign connected   = (r_state == ST_CONNECTED);
  assign idle        = (r_state == ST_IDLE);
  assign tok_granted = r_tok;
  assign outstanding = w_out;
  assign proto_err   = r_err;
endmodule

// File: tb/tb_dti_cr_conn_entry.sv
// Directed, table-driven bench for dti_cr_conn_entry with hand sequences for backpressure,
// token saturation and asynchronous reset during a pending disconnect-ack.
module tb_dti_cr_conn_entry;
  import dti_pack::*;

  logic        clk;
  logic        rst_n;
  logic        accept_en;
  logic        con_req;
  logic [5:0]  con_tid;
  logic [7:0]  con_tok;
  logic        dis_req;
  logic        trans_req;
  logic        trans_resp;
  logic        resp_ready;
  logic        resp_valid;
  logic [79:0] resp_data;
  logic [9:0]  resp_keep;
  logic        resp_last;
  logic        connected;
  logic        idle;
  logic [7:0]  tok_granted;
  logic [4:0]  outstanding;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  dti_cr_conn_entry dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_en   (accept_en),
    .con_req     (con_req),
    .con_tid     (con_tid),
    .con_tok     (con_tok),
    .dis_req     (dis_req),
    .trans_req   (trans_req),
    .trans_resp  (trans_resp),
    .resp_ready  (resp_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_keep   (resp_keep),
    .resp_last   (resp_last),
    .connected   (connected),
    .idle        (idle),
    .tok_granted (tok_granted),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cr, ae;
    logic [5:0] tid;
    logic [7:0] tok;
    logic       dr, tq, tr, rdy;
    logic       ev, ea;
    logic [7:0] etk;
    logic [5:0] etd;
    logic       ec, ei;
    logic [7:0] etg;
    logic [4:0] eo;
    logic       ee;
  } vec_t;

  // Inputs: con_req accept_en tid tok dis_req trans_req trans_resp ready.
  // Expected: valid accept tok_field tid_field connected idle tok_granted outstanding proto_err.
  function automatic vec_t mk(int cr, int ae, int tid, int tok, int dr, int tq, int tr, int rdy,
                              int ev, int ea, int etk, int etd, int ec, int ei, int etg, int eo, int ee);
    vec_t v;
    v.cr = 1'(cr);   v.ae = 1'(ae);   v.tid = 6'(tid); v.tok = 8'(tok);
    v.dr = 1'(dr);   v.tq = 1'(tq);   v.tr = 1'(tr);   v.rdy = 1'(rdy);
    v.ev = 1'(ev);   v.ea = 1'(ea);   v.etk = 8'(etk); v.etd = 6'(etd);
    v.ec = 1'(ec);   v.ei = 1'(ei);   v.etg = 8'(etg); v.eo = 5'(eo); v.ee = 1'(ee);
    return v;
  endfunction

  function automatic logic [127:0] exp_resp(logic v, logic a, logic [7:0] tk, logic [5:0] td);
    logic [79:0] d;
    logic [9:0]  k;
    d = '0;
    k = '0;
    if (v) begin
      d[3:0]   = DTI_MSG_CONDIS_ACK;
      d[4]     = a;
      d[15:8]  = tk;
      d[21:16] = td;
      k        = 10'h00f;
    end
    return 128'({v, v, k, d});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v, input string nm);
    chk({nm, " resp"}, 128'({resp_valid, resp_last, resp_keep, resp_data}),
        exp_resp(v.ev, v.ea, v.etk, v.etd));
    chk({nm, " status"}, 128'({connected, idle, tok_granted, outstanding, proto_err}),
        128'({v.ec, v.ei, v.etg, v.eo, v.ee}));
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    con_req    = v.cr;
    accept_en  = v.ae;
    con_tid    = v.tid;
    con_tok    = v.tok;
    dis_req    = v.dr;
    trans_req  = v.tq;
    trans_resp = v.tr;
    resp_ready = v.rdy;
    @(posedge clk);
    #1;
    check_outputs(v, nm);
  endtask

  vec_t tbl[24];

  initial begin
    tbl[0]  = mk(1,1,5,8,  0,0,0,1,  1,1,8,5,   0,0,8,0,0);
    tbl[1]  = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   1,0,8,0,0);
    tbl[2]  = mk(0,0,0,0,  0,1,0,1,  0,0,0,0,   1,0,8,1,0);
    tbl[3]  = mk(0,0,0,0,  0,1,0,1,  0,0,0,0,   1,0,8,2,0);
    tbl[4]  = mk(0,0,0,0,  0,1,0,1,  0,0,0,0,   1,0,8,3,0);
    tbl[5]  = mk(0,0,0,0,  1,0,0,1,  0,0,0,0,   0,0,8,3,0);
    tbl[6]  = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   0,0,8,3,0);
    tbl[7]  = mk(0,0,0,0,  0,0,1,1,  0,0,0,0,   0,0,8,2,0);
    tbl[8]  = mk(0,0,0,0,  0,0,1,1,  0,0,0,0,   0,0,8,1,0);
    tbl[9]  = mk(0,0,0,0,  0,0,1,1,  0,0,0,0,   0,0,8,0,0);
    tbl[10] = mk(0,0,0,0,  0,0,0,1,  1,0,0,5,   0,0,8,0,0);
    tbl[11] = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   0,1,0,0,0);
    tbl[12] = mk(1,1,9,0,  0,0,0,1,  1,0,0,9,   0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   0,1,0,0,0);
    tbl[14] = mk(1,0,3,8,  0,0,0,1,  1,0,0,3,   0,0,0,0,0);
    tbl[15] = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   0,1,0,0,0);
    tbl[16] = mk(1,1,7,40, 0,0,0,1,  1,1,16,7,  0,0,16,0,0);
    tbl[17] = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   1,0,16,0,0);
    tbl[18] = mk(0,0,0,0,  0,1,0,1,  0,0,0,0,   1,0,16,1,0);
    tbl[19] = mk(0,0,0,0,  0,1,1,1,  0,0,0,0,   1,0,16,1,0);
    tbl[20] = mk(0,0,0,0,  0,0,1,1,  0,0,0,0,   1,0,16,0,0);
    tbl[21] = mk(0,0,0,0,  1,0,0,1,  0,0,0,0,   0,0,16,0,0);
    tbl[22] = mk(0,0,0,0,  0,0,0,1,  1,0,0,7,   0,0,16,0,0);
    tbl[23] = mk(0,0,0,0,  0,0,0,1,  0,0,0,0,   0,1,0,0,0);

    rst_n = 1'b0; accept_en = 1'b0; con_req = 1'b0; con_tid = '0; con_tok = '0;
    dis_req = 1'b0; trans_req = 1'b0; trans_resp = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0,0,0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Accept beat held under backpressure for five cycles, handshake on the sixth.
    apply(mk(1,1,2,4, 0,0,0,0, 1,1,4,2, 0,0,4,0,0), "bp req");
    for (int i = 0; i < 5; i++)
      apply(mk(0,0,0,0, 0,0,0,0, 1,1,4,2, 0,0,4,0,0), $sformatf("bp hold%0d", i));
    apply(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1,0,4,0,0), "bp handshake");

    // Disconnect with nothing in flight: one DRAIN cycle, then a stalled ack hit by reset.
    apply(mk(0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0,4,0,0), "dis drain");
    apply(mk(0,0,0,0, 0,0,0,0, 1,0,0,2, 0,0,4,0,0), "dis ack");
    apply(mk(0,0,0,0, 0,0,0,0, 1,0,0,2, 0,0,4,0,0), "dis ack hold");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0,0,0), "async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh connection after reset with two tokens, then saturation.
    apply(mk(1,1,1,2, 0,0,0,0, 1,1,2,1, 0,0,2,0,0), "post-reset con");
    apply(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1,0,2,0,0), "post-reset conn");
    apply(mk(0,0,0,0, 0,1,0,1, 0,0,0,0, 1,0,2,1,0), "sat tq1");
    apply(mk(0,0,0,0, 0,1,0,1, 0,0,0,0, 1,0,2,2,0), "sat tq2");
    apply(mk(0,0,0,0, 0,1,0,1, 0,0,0,0, 1,0,2,2,1), "sat tq3");
    apply(mk(0,0,0,0, 0,0,1,1, 0,0,0,0, 1,0,2,1,1), "sat tr");
    apply(mk(0,0,0,0, 0,1,1,1, 0,0,0,0, 1,0,2,1,1), "sat both");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dti_cr_conn_entry.md
# dti_cr_conn_entry

Per-TBU connection responder on the TCU side of the DTI link. It accepts decoded connect and disconnect requests from one TBU and grants translation tokens. It tracks outstanding translations and emits single-beat CONDIS_ACK messages (accept, deny, disconnect-ack) on the custom response stream toward the TBU. One instance per TBU slot; it sits between the DTI message decoder and the response arbiter.

## Interface
- TBU_NUM_WIDTH, 6, TBU id width
- TRANSACTION_MAX_NUM, 16, max tokens grantable per connection
- CUSTOM_DATA_WIDTH, 80, response beat width
- CUSTOM_KEEP_WIDTH, 10, byte-keep width
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- accept_en  in  1  slot may accept new connections (sampled with con_req)
- con_req  in  1  connect request pulse
- con_tid  in  TBU_NUM_WIDTH  requesting TBU id
- con_tok  in  8  tokens requested
- dis_req  in  1  disconnect request pulse
- trans_req  in  1  translation request accepted from this TBU
- trans_resp  in  1  translation response sent to this TBU
- resp_ready  in  1  arbiter accepts beat
- resp_valid  out  1  response beat valid
- resp_data  out  CUSTOM_DATA_WIDTH  CONDIS_ACK payload
- resp_keep  out  CUSTOM_KEEP_WIDTH  byte keep
- resp_last  out  1  last beat
- connected  out  1  slot in CONNECTED
- idle  out  1  slot in IDLE
- tok_granted  out  8  tokens granted for current connection
- outstanding  out  $clog2(TRANSACTION_MAX_NUM)+1  in-flight translations
- proto_err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ACK_CON, DENY, CONNECTED, DRAIN, ACK_DIS.
- IDLE + con_req:
  - Go to ACK_CON if accept_en=1 and con_tok!=0. Latch con_tid and tok_granted=min(con_tok,TRANSACTION_MAX_NUM).
  - Otherwise go to DENY.
- ACK_CON: resp_valid=1 with the accept message. On resp_ready go to CONNECTED.
- DENY: resp_valid=1 with the deny message. On resp_ready go to IDLE.
- CONNECTED + dis_req: go to DRAIN.
- DRAIN: when outstanding==0, go to ACK_DIS in the next cycle.
- ACK_DIS: resp_valid=1 with the disconnect-ack message. On resp_ready go to IDLE and clear tok_granted.
- outstanding counter:
  - +1 on trans_req, -1 on trans_resp; both in the same cycle holds.
  - trans_req is legal in CONNECTED only. In DRAIN only trans_resp is legal.
- proto_err is set (sticky until reset) on any of:
  - trans_req outside CONNECTED;
  - trans_req while outstanding==tok_granted (counter saturates, no increment);
  - trans_resp while outstanding==0 (no decrement);
  - dis_req outside CONNECTED;
  - con_req outside IDLE.
- Every illegal request is otherwise ignored.
- Response beat:
  - resp_data[3:0]=DTI_MSG_CONDIS_ACK.
  - [4]=state (1 connect accepted, 0 disconnected or denied).
  - [15:8]=tok_granted (0 for deny or disconnect).
  - [21:16]=latched tid.
  - All other bits 0.
  - resp_keep=10'h00f, resp_last=1.

## Timing
- Reset values:
  - FSM=IDLE, idle=1, connected=0;
  - resp_valid=0, resp_data=0, resp_keep=0, resp_last=0;
  - tok_granted=0, outstanding=0, proto_err=0.
- Outputs are registered; resp_* are driven from the state register.
- con_req to resp_valid: 1 cycle.
- Valid/ready: resp_data, resp_keep and resp_last stay stable while resp_valid=1 and resp_ready=0. resp_valid never drops without a handshake.
- Handshake cycle: resp_valid deasserts the next cycle. The next state is visible the same edge.
- DRAIN exit: outstanding reaching 0 on edge N gives resp_valid=1 at N+1. If already 0 when dis_req arrives, the slot spends one cycle in DRAIN.
- outstanding arithmetic is unsigned, width $clog2(TRANSACTION_MAX_NUM)+1, and never wraps.
- Async reset mid-transfer drops resp_valid immediately; no completion is owed.

## Structure
- dti_pack holds:
  - DTI_MSG_CONDIS_ACK;
  - a conn_state_e enum;
  - the CONDIS_ACK field offsets;
  - CUSTOM_DATA_WIDTH, CUSTOM_KEEP_WIDTH, TBU_NUM_WIDTH, TRANSACTION_MAX_NUM.
- One natural sub-module: dti_cr_tok_cnt. It is the saturating up/down outstanding counter with overflow/underflow flags.

## Test plan
- con_req, con_tok=8, tid=5, accept_en=1 -> after 1 cycle resp_valid=1, data[4]=1, [15:8]=8, [21:16]=5, keep=0x00f; after ready, connected=1.
- con_tok=40 -> tok_granted=16. con_tok=0 or accept_en=0 -> deny beat with data[4]=0, [15:8]=0, then idle=1.
- Connected; 3 trans_req then dis_req; resp_ready held 1 -> no ack until 3 trans_resp. Ack is valid 1 cycle after the last trans_resp; then idle=1.
- resp_ready=0 for 5 cycles during ACK_CON -> data stable, valid held; ready on cycle 6 -> handshake, CONNECTED.
- tok_granted=2; 3 trans_req -> outstanding=2, proto_err=1. Simultaneous trans_req and trans_resp at outstanding=1 -> stays 1.
- rst_n asserted low during ACK_DIS with resp_ready=0 -> resp_valid=0 and idle=1 immediately. After release, a new con_req is accepted normally.
